// File: rtl/q_extractor_pkg.sv
// ----------------------------------------------------------------------------
// q_extractor_pkg: widths, FSM states and Q saturation for the charge extractor
// Optional macro: Q_SIGNED_EN (signed samples, Q clamped to [-2^30, 2^30-1])
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package q_extractor_pkg;

    localparam int SAMPLE_W = 31;
    localparam int GSUM_W   = 33;
    localparam int ACC_W    = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        POST  = 2'd2
    } state_t;

`ifdef Q_SIGNED_EN
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((64'd1 << 30) - 64'd1);
    localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

    function automatic logic [SAMPLE_W-1:0] saturate(input logic [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
        s = $signed(acc);
        if (s > Q_MAX)
            return Q_MAX[SAMPLE_W-1:0];
        else if (s < Q_MIN)
            return Q_MIN[SAMPLE_W-1:0];
        else
            return acc[SAMPLE_W-1:0];
    endfunction
`else
    function automatic logic [SAMPLE_W-1:0] saturate(input logic [ACC_W-1:0] acc);
        if (|acc[ACC_W-1:SAMPLE_W])
            return {SAMPLE_W{1'b1}};
        else
            return acc[SAMPLE_W-1:0];
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/q_history.sv
// ----------------------------------------------------------------------------
// q_history: DEPTH-deep delay line of group sums with a registered running sum
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module q_history
    import q_extractor_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ACC_W-1:0] g,
    output logic [ACC_W-1:0] sum
);

    generate
        if (DEPTH == 0) begin : g_none
            assign sum = '0;
        end else begin : g_line
            logic [ACC_W-1:0] taps [DEPTH];
            logic [ACC_W-1:0] run;

            // Running sum adds the newest group and drops the one leaving the line.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    run <= '0;
                    for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
                end else begin
                    taps[0] <= g;
                    for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
                    run <= run + g - taps[DEPTH-1];
                end
            end

            assign sum = run;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/q_extractor.sv
// ----------------------------------------------------------------------------
// q_extractor: integrates pulse charge over a trigger window with pre/post groups
// Optional macro: Q_SIGNED_EN (two's-complement samples). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module q_extractor
    import q_extractor_pkg::*;
#(
    parameter int PRE_GROUPS  = 2,
    parameter int POST_GROUPS = 2,
    parameter int MAX_GROUPS  = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                trig,
    input  logic [SAMPLE_W-1:0] in_0,
    input  logic [SAMPLE_W-1:0] in_1,
    input  logic [SAMPLE_W-1:0] in_2,
    input  logic [SAMPLE_W-1:0] in_3,
    output logic                valid_out,
    output logic [SAMPLE_W-1:0] Q
);

    localparam int CNT_W  = $clog2(MAX_GROUPS + 2);
    localparam int PCNT_W = 4;

    logic [GSUM_W-1:0] gsum;
    logic [ACC_W-1:0]  g_ext;
    logic [ACC_W-1:0]  hist_sum;

`ifdef Q_SIGNED_EN
    assign gsum  = {{2{in_0[SAMPLE_W-1]}}, in_0} + {{2{in_1[SAMPLE_W-1]}}, in_1}
                 + {{2{in_2[SAMPLE_W-1]}}, in_2} + {{2{in_3[SAMPLE_W-1]}}, in_3};
    assign g_ext = {{(ACC_W-GSUM_W){gsum[GSUM_W-1]}}, gsum};
`else
    assign gsum  = {2'b00, in_0} + {2'b00, in_1} + {2'b00, in_2} + {2'b00, in_3};
    assign g_ext = {{(ACC_W-GSUM_W){1'b0}}, gsum};
`endif

    q_history #(
        .DEPTH (PRE_GROUPS)
    ) u_history (
        .clk     (clk),
        .reset_n (reset_n),
        .g       (g_ext),
        .sum     (hist_sum)
    );

    state_t              state, state_nxt;
    logic [ACC_W-1:0]    acc, acc_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [PCNT_W-1:0]   pcnt, pcnt_nxt;
    logic                forced, forced_nxt;
    logic                lock, lock_nxt;
    logic                trig_prev;
    logic                fire;
    logic                rise;

    // A forced close keeps new windows shut until trig has been seen low.
    assign rise = trig && !trig_prev && !lock;

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        pcnt_nxt   = pcnt;
        forced_nxt = forced;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    acc_nxt    = hist_sum + g_ext;
                    cnt_nxt    = CNT_W'(PRE_GROUPS + 1);
                    forced_nxt = 1'b0;
                    state_nxt  = INTEG;
                end
            end
            INTEG: begin
                if (trig) begin
                    acc_nxt = acc + g_ext;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt_nxt >= CNT_W'(MAX_GROUPS)) begin
                        forced_nxt = 1'b1;
                        pcnt_nxt   = '0;
                        if (POST_GROUPS == 0) begin
                            fire      = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = POST;
                        end
                    end
                end else if (POST_GROUPS == 0) begin
                    fire      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    acc_nxt  = acc + g_ext;
                    pcnt_nxt = PCNT_W'(1);
                    if (POST_GROUPS == 1) begin
                        fire      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = POST;
                    end
                end
            end
            POST: begin
                acc_nxt  = acc + g_ext;
                pcnt_nxt = pcnt + PCNT_W'(1);
                // A retrigger inside the tail merges both pulses into one Q.
                if (trig && !forced) begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    state_nxt = INTEG;
                end else if (pcnt_nxt == PCNT_W'(POST_GROUPS)) begin
                    fire      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign lock_nxt = (fire && forced_nxt) ? trig : (lock && trig);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            pcnt      <= '0;
            forced    <= 1'b0;
            lock      <= 1'b0;
            trig_prev <= 1'b0;
            valid_out <= 1'b0;
            Q         <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            pcnt      <= pcnt_nxt;
            forced    <= forced_nxt;
            lock      <= lock_nxt;
            trig_prev <= trig;
            valid_out <= fire;
            if (fire)
                Q <= saturate(acc_nxt);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_q_extractor.sv
// ----------------------------------------------------------------------------
// tb_q_extractor: directed and random traces checked against a window-rule model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_q_extractor;

    localparam int PRE  = 2;
    localparam int POST = 2;
    localparam int MAX  = 64;
    localparam int MAXN = 256;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trig = 1'b0;
    logic [30:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;
    logic        valid_out;
    logic [30:0] q;

    always #5 clk = ~clk;

    q_extractor #(
        .PRE_GROUPS  (PRE),
        .POST_GROUPS (POST),
        .MAX_GROUPS  (MAX)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .trig      (trig),
        .in_0      (in_0),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_3      (in_3),
        .valid_out (valid_out),
        .Q         (q)
    );

    bit          trig_a [MAXN];
    logic [30:0] lane_a [MAXN][4];
    bit          dut_v  [MAXN];
    logic [30:0] dut_q  [MAXN];
    bit          exp_v  [MAXN];
    logic [30:0] exp_q  [MAXN];
    int          fill_n;
    int          vectors = 0;
    int          errors  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic longint lane_val(input logic [30:0] v);
`ifdef Q_SIGNED_EN
        return v[30] ? longint'(v) - (longint'(1) << 31) : longint'(v);
`else
        return longint'(v);
`endif
    endfunction

    function automatic longint group_val(input int t);
        return lane_val(lane_a[t][0]) + lane_val(lane_a[t][1])
             + lane_val(lane_a[t][2]) + lane_val(lane_a[t][3]);
    endfunction

    function automatic logic [30:0] ref_sat(input longint s);
        logic [63:0] r;
`ifdef Q_SIGNED_EN
        if (s > (longint'(1) << 30) - 1) s = (longint'(1) << 30) - 1;
        if (s < -(longint'(1) << 30))    s = -(longint'(1) << 30);
`else
        if (s > (longint'(1) << 31) - 1) s = (longint'(1) << 31) - 1;
`endif
        r = 64'(s);
        return r[30:0];
    endfunction

    task automatic add(input bit tv, input int len, input logic [30:0] lv);
        for (int i = 0; i < len && fill_n < MAXN; i++) begin
            trig_a[fill_n] = tv;
            for (int l = 0; l < 4; l++) lane_a[fill_n][l] = lv;
            fill_n++;
        end
    endtask

    task automatic add_rand(input bit tv, input int len, input bit big);
        for (int i = 0; i < len && fill_n < MAXN; i++) begin
            trig_a[fill_n] = tv;
            for (int l = 0; l < 4; l++)
                lane_a[fill_n][l] = big ? 31'($urandom) : 31'($urandom_range(0, 1000));
            fill_n++;
        end
    endtask

    // Expected outputs: each window is located from the trig trace and its
    // charge is the plain sum of the groups it spans.
    task automatic build_expected(input int n);
        int t, cur, t0, last_incl, out_t, n_in, m;
        bit done, complete, merged;
        longint s;
        logic [30:0] qh;
        qh = '0;
        t  = 0;
        while (t < n) begin
            if (trig_a[t] && (t == 0 || !trig_a[t-1])) begin
                t0 = t; n_in = PRE + 1; cur = t0; done = 0; complete = 0;
                last_incl = 0; out_t = n;
                while (!done) begin
                    cur++;
                    if (cur >= n) done = 1;
                    else if (trig_a[cur]) begin
                        n_in++;
                        if (n_in >= MAX) begin
                            last_incl = cur + POST; out_t = last_incl;
                            complete = (out_t < n); done = 1;
                        end
                    end else if (POST == 0) begin
                        last_incl = cur - 1; out_t = cur; complete = 1; done = 1;
                    end else begin
                        merged = 0; m = cur + 1;
                        while (!merged && m < cur + POST && m < n) begin
                            if (trig_a[m]) merged = 1; else m++;
                        end
                        if (merged) begin
                            n_in++; cur = m;
                        end else begin
                            last_incl = cur + POST - 1; out_t = last_incl;
                            complete = (out_t < n); done = 1;
                        end
                    end
                end
                if (!complete) out_t = n;
                for (int k = t; k < out_t; k++) begin exp_v[k] = 0; exp_q[k] = qh; end
                if (complete) begin
                    s = 0;
                    for (int k = t0 - PRE; k <= last_incl; k++)
                        if (k >= 0) s += group_val(k);
                    qh = ref_sat(s);
                    exp_v[out_t] = 1;
                    exp_q[out_t] = qh;
                end
                t = out_t + 1;
            end else begin
                exp_v[t] = 0; exp_q[t] = qh; t++;
            end
        end
    endtask

    // Starts and ends on a negedge; outputs sampled 1ns after each posedge.
    task automatic run_trace(input string name, input int n);
        for (int t = 0; t < n; t++) begin
            trig = trig_a[t];
            in_0 = lane_a[t][0]; in_1 = lane_a[t][1];
            in_2 = lane_a[t][2]; in_3 = lane_a[t][3];
            @(posedge clk);
            #1;
            dut_v[t] = valid_out;
            dut_q[t] = q;
            @(negedge clk);
        end
        trig = 1'b0;
        build_expected(n);
        for (int t = 0; t < n; t++) begin
            check($sformatf("%s valid_out[%0d]", name, t), 32'(dut_v[t]), 32'(exp_v[t]));
            check($sformatf("%s Q[%0d]", name, t), 32'(dut_q[t]), 32'(exp_q[t]));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        trig = 1'b0; in_0 = '0; in_1 = '0; in_2 = '0; in_3 = '0;
        repeat (2) @(negedge clk);
        check("reset valid_out", 32'(valid_out), 32'd0);
        check("reset Q", 32'(q), 32'd0);
        reset_n = 1'b1;
        fill_n = 0;
    endtask

    initial begin
        bit tv;
        bit big;
        int len;

        // Single pulse, constant lanes of 100.
        do_reset();
        add(0, 4, 31'd100); add(1, 3, 31'd100); add(0, 6, 31'd100);
        run_trace("pulse", fill_n);
        check("pulse strobe", 32'(dut_v[8]), 32'd1);
        check("pulse Q", 32'(dut_q[8]), 32'd2800);

        // Only the pre-trigger groups carry charge.
        do_reset();
        add(0, 4, 31'd100); add(1, 3, 31'd0); add(0, 6, 31'd0);
        run_trace("pre_only", fill_n);
        check("pre_only Q", 32'(dut_q[8]), 32'd800);

        // Two pulses one low group apart share one Q.
        do_reset();
        add(0, 4, 31'd10); add(1, 3, 31'd10); add(0, 1, 31'd10);
        add(1, 3, 31'd10); add(0, 6, 31'd10);
        run_trace("merge", fill_n);
        check("merge Q", 32'(dut_q[12]), 32'd440);

        // Stuck trigger forces a close, then a fresh pulse after trig drops.
        do_reset();
        add(0, 3, 31'd1); add(1, 80, 31'd1); add(0, 3, 31'd1);
        add(1, 5, 31'd1); add(0, 5, 31'd1);
        run_trace("forced", fill_n);
        check("forced strobe", 32'(dut_v[66]), 32'd1);
        check("forced Q", 32'(dut_q[66]), 32'd264);
        check("forced no reopen", 32'(dut_v[82]), 32'd0);

        // Saturation with full-scale lanes.
        do_reset();
        add(0, 3, 31'h7FFF_FFFF); add(1, 10, 31'h7FFF_FFFF); add(0, 5, 31'h7FFF_FFFF);
        run_trace("sat", fill_n);
`ifdef Q_SIGNED_EN
        check("sat Q", 32'(dut_q[14]), 32'h7FFF_FFC8);
`else
        check("sat Q", 32'(dut_q[14]), 32'h7FFF_FFFF);
`endif

        // Back-to-back windows, then a window left open when reset hits.
        do_reset();
        add(0, 3, 31'd5); add(1, 2, 31'd5); add(0, 2, 31'd5);
        add(1, 2, 31'd5); add(0, 4, 31'd5); add(1, 3, 31'd5);
        run_trace("b2b", fill_n);
        check("b2b strobe", 32'(dut_v[10]), 32'd1);
        check("b2b Q", 32'(dut_q[10]), 32'd120);
        reset_n = 1'b0;
        #1;
        check("midreset valid_out", 32'(valid_out), 32'd0);
        check("midreset Q", 32'(q), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fill_n = 0;
        add(0, 3, 31'd7); add(1, 2, 31'd7); add(0, 5, 31'd7);
        run_trace("after_reset", fill_n);
        check("after_reset Q", 32'(dut_q[6]), 32'd168);

        // Random trigger patterns and lane values.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            big = (r % 2) == 1;
            tv  = 1'b0;
            while (fill_n < 150) begin
                len = (tv && $urandom_range(0, 9) == 0) ? 70 : $urandom_range(1, 6);
                add_rand(tv, len, big);
                tv = !tv;
            end
            run_trace($sformatf("rand%0d", r), 150);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/q_extractor.md
Name: q_extractor

Overview:
- Integrates pulse charge (Q) from the FIR-filtered sample stream, 4 samples per clock ("group").
- Opens an integration window around each trigger (OR of the TOT bits).
- Window adds pre-trigger and post-trigger groups.
- Emits one Q word with a single-cycle valid strobe; sits downstream of the FIR trigger block, parallel to the CFD time extractor.

Parameters:
- PRE_GROUPS, 2, groups preceding the trigger rising edge included in Q (0..8).
- POST_GROUPS, 2, groups after the trigger falls included in Q; the first trig-low group counts (0..8).
- MAX_GROUPS, 64, maximum groups in the PRE+INTEG portion before a forced window close.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- trig  in  1  trigger level, sampled each clk
- in_0  in  31  filtered sample, earliest in group
- in_1  in  31  filtered sample 1
- in_2  in  31  filtered sample 2
- in_3  in  31  filtered sample, latest in group
- valid_out  out  1  one-cycle strobe, Q valid
- Q  out  31  integrated charge, saturating

Behaviour:
- Reset: one clock, asynchronous active-low reset (reset_n); all registers clear asynchronously.
  - valid_out=0, Q=0, state IDLE, history=0, trig_prev=0.
- Group sum G = in_0+in_1+in_2+in_3, computed combinationally at 33 bits, unsigned.
- Accumulator is 40 bits.
- History: shift register of the last PRE_GROUPS values of G. It updates every cycle in every state.
- Rising edge = trig=1 and trig_prev=0. trig_prev resets to 0, so trig high out of reset counts as an edge.
- IDLE, on rising edge:
  - acc <= sum(history) + G; cnt <= PRE_GROUPS+1; go INTEG.
- INTEG, trig=1:
  - acc += G; cnt++.
  - If cnt reaches MAX_GROUPS, go POST with the forced flag set.
- INTEG, trig=0:
  - If POST_GROUPS=0: output acc and go IDLE.
  - Otherwise: acc += G; pcnt <= 1; go POST. If pcnt then equals POST_GROUPS, output instead.
- POST:
  - acc += G; pcnt++.
  - Output when pcnt reaches POST_GROUPS.
  - If trig=1 and not forced, return to INTEG (merged pulses). Merged pulses share one Q.
- Output (registered at the edge sampling the last included group):
  - valid_out <= 1 for exactly one cycle.
  - Q <= min(acc_final, 2^31-1).
  - State goes IDLE. Q holds its value until the next output.
- Forced window: after a forced close, no new window opens until trig has been sampled low at least once.
- Back-to-back: a rising edge on the cycle immediately after output opens a new window.
- Reset mid-window: window discarded, no valid_out.

Optional Feature:
- Macro Q_SIGNED_EN.
- Defined:
  - in_0..in_3 are two's-complement signed; G and acc are sign-extended.
  - Q saturates to [-2^30, 2^30-1].
- Undefined: unsigned as above, saturating at 2^31-1.

Decomposition:
- Package q_extractor_pkg:
  - SAMPLE_W=31, GSUM_W=33, ACC_W=40.
  - State enum {IDLE, INTEG, POST}.
  - Saturation function.
- One sub-module q_history: the PRE_GROUPS-deep G delay line with a registered running sum output.

Test Plan:
- All lanes 100 (G=400); trig high at edges k..k+2, low at k+3 -> 7 groups; valid_out high after edge k+4; Q=2800.
- Same stimulus, lanes 100 before edge k and 0 from edge k onward -> Q=800 (pre-trigger groups only).
- Two trig pulses separated by 1 low group, lanes 10 -> single valid_out; Q=40×(2+3+1+3+2)=440.
- trig stuck high, lanes 1 -> forced close: valid_out once, Q=4×(64+2)=264; no second Q until trig drops and rises again.
- Lanes 0x7FFFFFFF, trig high for 10 groups -> Q=0x7FFFFFFF (saturated).
- Pull reset_n low during INTEG -> valid_out stays 0, Q=0; with trig low, the next trig rise gives a normal Q.
